accumulator_bank: RTL and testbench

Parametrised successor of the fixed 256-entry accumulator buffer that sits behind the systolic array (MMU). Holds LANES signed partial sums per address; the write port either overwrites or accumulates incoming MMU row results via a 2-stage read-modify-write pipeline with hazard forwarding. Adds optional saturation, a hardware clear sweep and a registered read port with a valid flag.

---
 rtl/accumulator_bank_pkg.sv | 22 ++
 rtl/accumulator_bank_if.sv | 32 +++
 rtl/acc_lane_alu.sv | 38 +++
 rtl/accumulator_bank.sv | 148 ++++++++++++++
 tb/tb_accumulator_bank.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/accumulator_bank_pkg.sv
// Shared definitions for the accumulator bank: clear-sweep FSM states and
// the address-width helper used to derive ADDR_W from DEPTH.
package accumulator_bank_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } clr_state_e;

    // Smallest width able to index 'value' entries (minimum 1 bit).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/accumulator_bank_if.sv
// Bundle of the accumulator bank's write, read and clear signals.
//   master : the MMU-side driver (write port, read port, clear request)
//   slave  : the accumulator bank itself
interface accumulator_bank_if #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned ADDR_W = 8
);
    logic                     wea;
    logic                     acc_en;
    logic                     sat_en;
    logic [ADDR_W-1:0]        addra;
    logic [LANES*IN_W-1:0]    dina;
    logic                     enb;
    logic [ADDR_W-1:0]        addrb;
    logic [LANES*ACC_W-1:0]   doutb;
    logic                     doutb_valid;
    logic                     clr_start;
    logic                     clr_busy;
    logic                     wr_drop;

    modport master (
        output wea, acc_en, sat_en, addra, dina, enb, addrb, clr_start,
        input  doutb, doutb_valid, clr_busy, wr_drop
    );

    modport slave (
        input  wea, acc_en, sat_en, addra, dina, enb, addrb, clr_start,
        output doutb, doutb_valid, clr_busy, wr_drop
    );
endinterface

// File: rtl/acc_lane_alu.sv
// One accumulator lane: optional accumulate onto the old value, then
// saturate or wrap the ACC_W+1-bit sum back to ACC_W bits.
//   old_i    : current entry value (signed, ACC_W)
//   din_i    : incoming lane (signed, IN_W), sign-extended here
//   acc_en_i : 1 = old + din, 0 = din alone
//   sat_en_i : 1 = clamp on overflow, 0 = keep low ACC_W bits
//   sum_o    : result to commit
module acc_lane_alu #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 20
) (
    input  logic [ACC_W-1:0] old_i,
    input  logic [IN_W-1:0]  din_i,
    input  logic             acc_en_i,
    input  logic             sat_en_i,
    output logic [ACC_W-1:0] sum_o
);
    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] old_ext;
    logic [ACC_W:0] din_ext;
    logic [ACC_W:0] sum_wide;
    logic           ovf;

    always_comb begin
        old_ext  = acc_en_i ? {old_i[ACC_W-1], old_i} : '0;
        din_ext  = {{(ACC_W+1-IN_W){din_i[IN_W-1]}}, din_i};
        sum_wide = old_ext + din_ext;
        // Top two bits disagree only when the result leaves the ACC_W range.
        ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (sat_en_i && ovf) begin
            sum_o = sum_wide[ACC_W] ? AccMin : AccMax;
        end else begin
            sum_o = sum_wide[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/accumulator_bank.sv
// LANES-wide signed accumulator buffer behind the systolic array.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : write port (wea/acc_en/sat_en/addra/dina), registered read
//                port (enb/addrb -> doutb/doutb_valid), clear sweep
//                (clr_start -> clr_busy) and wr_drop for writes refused
//                during a sweep.
// Writes run through a 2-stage read-modify-write pipeline; S0 forwards the
// S1 result on an address match so back-to-back accumulates are exact.
module accumulator_bank
    import accumulator_bank_pkg::*;
#(
    parameter int unsigned LANES = 16,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned ACC_W = 20,
    parameter int unsigned DEPTH = 256
) (
    input logic             clk,
    input logic             reset,
    accumulator_bank_if.slave bus
);
    localparam int unsigned ADDR_W = clogb2(DEPTH);
    localparam int unsigned DIN_W  = LANES * IN_W;
    localparam int unsigned DOUT_W = LANES * ACC_W;

    typedef logic [ADDR_W-1:0] addr_t;
    localparam addr_t LastAddr = addr_t'(DEPTH - 1);

    logic [DOUT_W-1:0] mem [DEPTH];

    logic              s1_valid_q, s1_valid_d;
    logic              s1_acc_q, s1_acc_d;
    logic              s1_sat_q, s1_sat_d;
    addr_t             s1_addr_q, s1_addr_d;
    logic [DIN_W-1:0]  s1_din_q, s1_din_d;
    logic [DOUT_W-1:0] s1_old_q, s1_old_d;
    logic [DOUT_W-1:0] s1_sum;

    clr_state_e        state_q, state_d;
    addr_t             cnt_q, cnt_d;

    logic [DOUT_W-1:0] doutb_q, doutb_d;
    logic              doutb_valid_q, doutb_valid_d;
    logic              wr_drop_q, wr_drop_d;

    logic              clr_we;
    logic              mem_we;
    addr_t             mem_waddr;
    logic [DOUT_W-1:0] mem_wdata;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        acc_lane_alu #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W)
        ) u_alu (
            .old_i    (s1_old_q[k*ACC_W +: ACC_W]),
            .din_i    (s1_din_q[k*IN_W +: IN_W]),
            .acc_en_i (s1_acc_q),
            .sat_en_i (s1_sat_q),
            .sum_o    (s1_sum[k*ACC_W +: ACC_W])
        );
    end

    // Clear sweep: one entry per cycle, DEPTH cycles total.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s1_valid_d = bus.wea && (state_q == StIdle);
        s1_acc_d   = bus.acc_en;
        s1_sat_d   = bus.sat_en;
        s1_addr_d  = bus.addra;
        s1_din_d   = bus.dina;
        // Forward the not-yet-committed S1 result on an address match.
        if (s1_valid_q && (bus.addra == s1_addr_q)) begin
            s1_old_d = s1_sum;
        end else begin
            s1_old_d = mem[bus.addra];
        end
        wr_drop_d     = bus.wea && (state_q == StClear);
        doutb_valid_d = bus.enb;
        doutb_d       = bus.enb ? mem[bus.addrb] : doutb_q;

        // A sweep write wins over S1; the only S1 write that can overlap is
        // the first sweep cycle, and the sweep zeroes that entry regardless.
        mem_we    = !reset && (clr_we || s1_valid_q);
        mem_waddr = clr_we ? cnt_q : s1_addr_q;
        mem_wdata = clr_we ? '0 : s1_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_acc_q      <= 1'b0;
            s1_sat_q      <= 1'b0;
            s1_addr_q     <= '0;
            s1_din_q      <= '0;
            s1_old_q      <= '0;
            state_q       <= StIdle;
            cnt_q         <= '0;
            doutb_q       <= '0;
            doutb_valid_q <= 1'b0;
            wr_drop_q     <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_acc_q      <= s1_acc_d;
            s1_sat_q      <= s1_sat_d;
            s1_addr_q     <= s1_addr_d;
            s1_din_q      <= s1_din_d;
            s1_old_q      <= s1_old_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            doutb_q       <= doutb_d;
            doutb_valid_q <= doutb_valid_d;
            wr_drop_q     <= wr_drop_d;
        end
    end

    // Storage is left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.doutb       = doutb_q;
    assign bus.doutb_valid = doutb_valid_q;
    assign bus.clr_busy    = (state_q == StClear);
    assign bus.wr_drop     = wr_drop_q;
endmodule

// File: tb/tb_accumulator_bank.sv
// Bench for accumulator_bank: directed vector table, hand-written
// saturation / clear / reset-mid-clear sequences and a randomized phase
// checked against an array model where writes become readable two cycles
// after issue (read-first).
module tb_accumulator_bank;
    import accumulator_bank_pkg::*;

    localparam int unsigned LANES  = 16;
    localparam int unsigned IN_W   = 16;
    localparam int unsigned ACC_W  = 20;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = clogb2(DEPTH);
    localparam int unsigned DIN_W  = LANES * IN_W;
    localparam int unsigned DOUT_W = LANES * ACC_W;
    localparam longint AccMaxI = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint AccMinI = -(64'sd1 <<< (ACC_W - 1));

    typedef int lanes_t [LANES];

    typedef struct {
        bit w; bit acc; bit sat; int addr; int val;
        bit rd; int raddr; bit exp_valid; bit chk_dout; int exp_val;
    } vec_t;

    logic clk;
    logic reset;
    accumulator_bank_if #(
        .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
    ) bus ();

    accumulator_bank #(
        .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wea) assert (int'(bus.addra) < int'(DEPTH)) else $error("illegal write address");
    end

    int     n_vec = 0;
    int     n_err = 0;
    lanes_t ref_mem [DEPTH];
    bit     pend_valid;
    int     pend_addr;
    lanes_t pend_val;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DOUT_W-1:0] act,
                         input logic [DOUT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DIN_W-1:0] splat_in(input int v);
        logic [DIN_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*IN_W +: IN_W] = v[IN_W-1:0];
        return r;
    endfunction

    function automatic logic [DOUT_W-1:0] splat_acc(input int v);
        logic [DOUT_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
        return r;
    endfunction

    function automatic logic [DIN_W-1:0] pack_in(input lanes_t v);
        logic [DIN_W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            int t;
            t = v[k];
            r[k*IN_W +: IN_W] = t[IN_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [DOUT_W-1:0] pack_acc(input lanes_t v);
        logic [DOUT_W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            int t;
            t = v[k];
            r[k*ACC_W +: ACC_W] = t[ACC_W-1:0];
        end
        return r;
    endfunction

    // Reference arithmetic straight from the rules: signed add, then clamp or wrap.
    function automatic int lane_op(input int old, input int x, input bit acc, input bit sat);
        longint s;
        s = (acc ? longint'(old) : 64'sd0) + longint'(x);
        if (sat) begin
            if (s > AccMaxI) s = AccMaxI;
            if (s < AccMinI) s = AccMinI;
        end else begin
            s = s & ((64'sd1 <<< ACC_W) - 1);
            if (s > AccMaxI) s = s - (64'sd1 <<< ACC_W);
        end
        return int'(s);
    endfunction

    task automatic raw(input bit w, input bit acc, input bit sat, input int addr,
                       input int val, input bit rd, input int raddr);
        bus.wea    = w;
        bus.acc_en = acc;
        bus.sat_en = sat;
        bus.addra  = ADDR_W'(addr);
        bus.dina   = splat_in(val);
        bus.enb    = rd;
        bus.addrb  = ADDR_W'(raddr);
        tick();
    endtask

    // One model-tracked cycle; a write becomes visible to reads two cycles later.
    task automatic drive_cycle(input bit w, input bit acc, input bit sat, input int addr,
                               input lanes_t vals, input bit rd, input int raddr,
                               input string tag);
        logic [DOUT_W-1:0] exp_rd;
        lanes_t base;
        lanes_t nv;
        bus.wea    = w;
        bus.acc_en = acc;
        bus.sat_en = sat;
        bus.addra  = ADDR_W'(addr);
        bus.dina   = pack_in(vals);
        bus.enb    = rd;
        bus.addrb  = ADDR_W'(raddr);
        exp_rd = pack_acc(ref_mem[raddr]);
        if (pend_valid && pend_addr == addr) base = pend_val;
        else base = ref_mem[addr];
        for (int k = 0; k < LANES; k++) nv[k] = lane_op(base[k], vals[k], acc, sat);
        tick();
        if (pend_valid) ref_mem[pend_addr] = pend_val;
        pend_valid = w;
        pend_addr  = addr;
        pend_val   = nv;
        check($sformatf("%s.valid", tag), DOUT_W'(bus.doutb_valid), DOUT_W'(rd));
        if (rd) check($sformatf("%s.doutb[%0d]", tag, raddr), bus.doutb, exp_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl [20];
        lanes_t zero;
        lanes_t vals;
        int     busy_cnt;
        int     guard;

        for (int k = 0; k < LANES; k++) zero[k] = 0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = zero;
        pend_valid = 0;
        pend_addr  = 0;
        pend_val   = zero;

        // w acc sat addr val rd raddr exp_valid chk_dout exp_val
        tbl[0]  = '{1, 0, 0, 5, -3,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,   1, 5, 1, 1, -3};
        tbl[3]  = '{1, 0, 0, 7, 100, 0, 0, 0, 1, -3};
        tbl[4]  = '{1, 1, 0, 7, 10,  0, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 7, 10,  0, 0, 0, 0, 0};
        tbl[6]  = '{1, 1, 0, 7, 10,  0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0,   1, 7, 1, 1, 130};
        tbl[9]  = '{1, 0, 0, 9, 20,  0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 9, 50,  0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0,   1, 9, 1, 1, 20};
        tbl[13] = '{0, 0, 0, 0, 0,   1, 9, 1, 1, 50};
        tbl[14] = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 50};
        tbl[15] = '{1, 1, 0, 7, -30, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 7, 5,   0, 0, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 0,   1, 7, 1, 1, 105};

        // Reset state.
        reset = 1'b1;
        bus.wea = 0; bus.acc_en = 0; bus.sat_en = 0; bus.addra = '0; bus.dina = '0;
        bus.enb = 0; bus.addrb = '0; bus.clr_start = 0;
        tick();
        tick();
        check("rst.doutb", bus.doutb, '0);
        check("rst.valid", DOUT_W'(bus.doutb_valid), '0);
        check("rst.clr_busy", DOUT_W'(bus.clr_busy), '0);
        check("rst.wr_drop", DOUT_W'(bus.wr_drop), '0);
        reset = 1'b0;

        // Directed table: overwrite, back-to-back accumulate, read-first, hold.
        for (int i = 0; i < 20; i++) begin
            raw(tbl[i].w, tbl[i].acc, tbl[i].sat, tbl[i].addr, tbl[i].val,
                tbl[i].rd, tbl[i].raddr);
            check($sformatf("tbl%0d.valid", i), DOUT_W'(bus.doutb_valid),
                  DOUT_W'(tbl[i].exp_valid));
            if (tbl[i].chk_dout)
                check($sformatf("tbl%0d.doutb", i), bus.doutb, splat_acc(tbl[i].exp_val));
        end

        // Saturation and wrap at both ends of the range.
        raw(1, 0, 1, 1, 32767, 0, 0);
        repeat (15) raw(1, 1, 1, 1, 32767, 0, 0);
        raw(1, 1, 1, 1, 15, 0, 0);
        raw(1, 1, 1, 1, 1, 0, 0);
        raw(0, 0, 0, 0, 0, 0, 0);
        raw(0, 0, 0, 0, 0, 1, 1);
        check("sat.pos_clamp", bus.doutb, splat_acc(524287));
        raw(1, 1, 0, 1, 1, 0, 0);
        raw(0, 0, 0, 0, 0, 0, 0);
        raw(0, 0, 0, 0, 0, 1, 1);
        check("sat.pos_wrap", bus.doutb, splat_acc(-524288));
        raw(1, 1, 1, 1, -32768, 0, 0);
        raw(0, 0, 0, 0, 0, 0, 0);
        raw(0, 0, 0, 0, 0, 1, 1);
        check("sat.neg_clamp", bus.doutb, splat_acc(-524288));
        raw(1, 1, 0, 1, -1, 0, 0);
        raw(0, 0, 0, 0, 0, 0, 0);
        raw(0, 0, 0, 0, 0, 1, 1);
        check("sat.neg_wrap", bus.doutb, splat_acc(524287));

        // Fill every entry nonzero, then sweep; last fill write is still in S1
        // when clr_start is accepted.
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int k = 0; k < LANES; k++) vals[k] = i + k + 1;
            drive_cycle(1, 0, 0, i, vals, 0, 0, "fill");
        end
        bus.clr_start = 1'b1;
        drive_cycle(0, 0, 0, 0, zero, 0, 0, "clr_go");
        bus.clr_start = 1'b0;
        check("clr.busy_rise", DOUT_W'(bus.clr_busy), DOUT_W'(1));
        busy_cnt = 0;
        guard = 0;
        bus.addra = ADDR_W'(20);
        bus.dina  = splat_in(77);
        bus.acc_en = 0;
        while (bus.clr_busy && guard < 400) begin
            busy_cnt++;
            bus.wea = (guard == 50);
            if (guard == 51) check("clr.wr_drop_pulse", DOUT_W'(bus.wr_drop), DOUT_W'(1));
            if (guard == 52) check("clr.wr_drop_end", DOUT_W'(bus.wr_drop), '0);
            bus.clr_start = (guard == 150);
            tick();
            guard++;
        end
        bus.wea = 0;
        bus.clr_start = 0;
        check("clr.busy_cycles", DOUT_W'(busy_cnt), DOUT_W'(DEPTH));
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = zero;
        for (int i = 0; i < int'(DEPTH); i++) drive_cycle(0, 0, 0, 0, zero, 1, i, "clr_rd");

        // Refill, then reset with the sweep counter at 100.
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int k = 0; k < LANES; k++) vals[k] = int'($urandom_range(1, 32767));
            drive_cycle(1, 0, 0, i, vals, 0, 0, "refill");
        end
        bus.clr_start = 1'b1;
        drive_cycle(0, 0, 0, 0, zero, 0, 0, "clr_go2");
        bus.clr_start = 1'b0;
        for (int j = 0; j < 100; j++) begin
            bus.enb   = (j == 50) || (j == 60);
            bus.addrb = (j == 50) ? ADDR_W'(10) : ADDR_W'(250);
            if (j == 51) check("mid.rd_swept", bus.doutb, '0);
            if (j == 61) check("mid.rd_unswept", bus.doutb, pack_acc(ref_mem[250]));
            tick();
        end
        bus.enb = 0;
        check("mid.busy_at_100", DOUT_W'(bus.clr_busy), DOUT_W'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid.rst_busy", DOUT_W'(bus.clr_busy), '0);
        check("mid.rst_doutb", bus.doutb, '0);
        check("mid.rst_valid", DOUT_W'(bus.doutb_valid), '0);
        for (int i = 0; i < 100; i++) ref_mem[i] = zero;
        pend_valid = 0;
        for (int i = 0; i < int'(DEPTH); i++) drive_cycle(0, 0, 0, 0, zero, 1, i, "abort_rd");

        // Random traffic on a few addresses to provoke hazards and overflow.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            for (int k = 0; k < LANES; k++) begin
                if (sel == 0) vals[k] = 32767;
                else if (sel == 1) vals[k] = -32768;
                else vals[k] = int'($urandom_range(0, 65535)) - 32768;
            end
            drive_cycle(($urandom_range(0, 9) < 7), bit'($urandom_range(0, 1)),
                        bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), vals,
                        bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), "rnd");
        end
        drive_cycle(0, 0, 0, 0, zero, 0, 0, "flush");
        for (int i = 0; i < 8; i++) drive_cycle(0, 0, 0, 0, zero, 1, i, "final_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
